pic10_fetch_seq: RTL and testbench
==================================

Name: pic10_fetch_seq

Overview:
- Instruction fetch/sequencer stage for the PIC10F200-compatible core, directly upstream of the opcode ALU.
- Holds the program counter, the instruction register that drives the ALU's 12-bit opcode input, and the 2-level hardware stack.
- Resolves GOTO, CALL, RETLW, PCL writes and skip requests, flushing the pipeline with a NOP bubble on every control transfer.
- Two-stage pipeline: fetch of PC+1 overlaps execute of the current instruction, as in the baseline PIC.

Parameters:
- PC_W, 8, program counter width in bits; 8 gives 256 words (10F200), 9 gives 512 words.
- RESET_VEC, {PC_W{1'b1}}, PC value loaded on reset; the last word holds the calibration MOVLW.

Ports:
- clk  in  1  single system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  advance enable; 0 freezes all state.
- pm_addr  out  PC_W  program memory address; equals pc combinationally.
- pm_rdata  in  12  program memory word at pm_addr; asynchronous-read ROM, valid in the same cycle.
- skip_req  in  1  from execute: skip the next instruction (BTFSC/BTFSS/DECFSZ/INCFSZ outcome).
- pcl_wr  in  1  from execute: current instruction writes PCL (f=0x02).
- pcl_data  in  8  value written to PCL.
- opcode  out  12  instruction register; feeds the ALU opcode input.
- opcode_pc  out  PC_W  address of the instruction in opcode.
- exec_valid  out  1  opcode holds a real fetched instruction, not a flush bubble.
- retlw_wr  out  1  combinational write strobe for W on RETLW.
- retlw_k  out  8  literal for W, equal to opcode[7:0].
- stk_ovf  out  1  sticky flag: push while the stack is full.
- stk_unf  out  1  sticky flag: pop while the stack is empty.

Behaviour:
- Reset, asynchronous: pc=RESET_VEC, opcode=12'h000 (NOP), opcode_pc=0, exec_valid=0, stk[0]=stk[1]=0, depth=0, stk_ovf=stk_unf=0.
- Decode of opcode:
  - GOTO: opcode[11:9]=3'b101, target = opcode[PC_W-1:0].
  - CALL: opcode[11:8]=4'b1001, target = zero-extended opcode[7:0].
  - RETLW: opcode[11:8]=4'b1000.
- Control-transfer decode counts only when exec_valid=1. skip_req and pcl_wr are also ignored when exec_valid=0.
- Normal cycle (en=1, no transfer): opcode<=pm_rdata, opcode_pc<=pc, pc<=pc+1 mod 2^PC_W, exec_valid<=1.
- Wrap: RESET_VEC+1 wraps to 0, so the first executed instruction is the word at RESET_VEC, then address 0.
- Transfer cycle (en=1, one of the events below): pc<=target, opcode<=NOP, exec_valid<=0. Exactly one bubble per transfer. Priority is highest first:
  1. GOTO: target as decoded.
  2. CALL: push pc (already the return address, opcode_pc+1), then pc<=target.
  3. RETLW: pc<=stk[0] (pop); retlw_wr=1 this cycle.
  4. pcl_wr: pc<={zeros, pcl_data}, clearing PC bits above bit 7.
  5. skip_req: pc<=pc+1, discarding the prefetched word.
- Push: stk[1]<=stk[0], stk[0]<=pc, depth<=min(depth+1,2). If depth was already 2, the oldest entry is lost and stk_ovf<=1.
- Pop: stk[0]<=stk[1]; stk[1] is unchanged; depth<=max(depth-1,0). If depth was already 0, the stale stk[0] is still used and stk_unf<=1.
- retlw_wr = en & exec_valid & RETLW decode. retlw_k = opcode[7:0] at all times.
- en=0: pc, opcode, opcode_pc, exec_valid, stack and flags all hold; retlw_wr=0; pm_addr stays at pc.
- Reset asserted mid-transfer or mid-stall: immediately returns to the reset state; no pending push or pop survives.
- Sticky flags clear only on rst.

Test Plan:
- Reset release, ROM[FF]=C25 (MOVLW), ROM[00]=000 -> cycle 1: opcode=C25, opcode_pc=FF, exec_valid=1; cycle 2: opcode_pc=00, pm_addr=01.
- ROM[05]=A40 (GOTO 0x40) -> next cycle: opcode=000, exec_valid=0, pm_addr=40; following cycle: opcode_pc=40.
- ROM[10]=910 (CALL 0x10 from 0x10), ROM[10] replaced by CALL at 0x03 with RETLW 0x55 at 0x10 -> after RETLW: retlw_wr=1, retlw_k=55, pc returns to 0x04, depth=0, one bubble each way.
- Three nested CALLs without return -> stk_ovf=1; three RETLWs -> third returns to the second-level address (stale stk[0]), stk_unf=1.
- skip_req=1 while executing 0x20 -> word at 0x21 never appears with exec_valid=1; next valid opcode_pc=0x22. skip_req during a bubble -> ignored.
- en=0 for 3 cycles mid-stream, then pcl_wr=1, pcl_data=0x80 -> state frozen while en=0; after release pm_addr=0x80 and a bubble is inserted. rst pulse mid-stall -> pc=FF, exec_valid=0.

Source files
------------

// File: rtl/pic10_fetch_seq.sv
// pic10_fetch_seq: PIC10 fetch/sequencer with PC, instruction register, 2-level stack and flush bubbles
module pic10_fetch_seq #(
  parameter int PC_W = 8,
  parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b1}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  output logic [PC_W-1:0] pm_addr,
  input  logic [11:0]     pm_rdata,
  input  logic            skip_req,
  input  logic            pcl_wr,
  input  logic [7:0]      pcl_data,
  output logic [11:0]     opcode,
  output logic [PC_W-1:0] opcode_pc,
  output logic            exec_valid,
  output logic            retlw_wr,
  output logic [7:0]      retlw_k,
  output logic            stk_ovf,
  output logic            stk_unf
);
  logic [PC_W-1:0] pc, stk0, stk1, pc_inc, pc_nxt;
  logic [1:0] depth;
  logic is_goto, is_call, is_ret, do_pcl, do_skip, xfer;
  always_comb begin
    is_goto = exec_valid && opcode[11:9] == 3'b101;
    is_call = exec_valid && opcode[11:8] == 4'b1001;
    is_ret  = exec_valid && opcode[11:8] == 4'b1000;
    do_pcl  = exec_valid && pcl_wr;
    do_skip = exec_valid && skip_req;
    xfer    = is_goto || is_call || is_ret || do_pcl || do_skip;
    pc_inc  = pc + PC_W'(1);
    pc_nxt  = is_goto ? opcode[PC_W-1:0] :
              is_call ? PC_W'(opcode[7:0]) :
              is_ret  ? stk0 :
              do_pcl  ? PC_W'(pcl_data) : pc_inc;
    pm_addr  = pc;
    retlw_wr = en && is_ret;
    retlw_k  = opcode[7:0];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= RESET_VEC;
      opcode     <= '0;
      opcode_pc  <= '0;
      exec_valid <= 1'b0;
      stk0       <= '0;
      stk1       <= '0;
      depth      <= '0;
      stk_ovf    <= 1'b0;
      stk_unf    <= 1'b0;
    end else if (en) begin
      pc         <= pc_nxt;
      opcode     <= xfer ? 12'h000 : pm_rdata;
      opcode_pc  <= pc;
      exec_valid <= !xfer;
      // pc already points past the CALL, so it is the return address
      if (is_call) begin
        stk1  <= stk0;
        stk0  <= pc;
        depth <= (depth == 2'd2) ? 2'd2 : depth + 2'd1;
        if (depth == 2'd2) stk_ovf <= 1'b1;
      end else if (is_ret) begin
        stk0  <= stk1;
        depth <= (depth == 2'd0) ? 2'd0 : depth - 2'd1;
        if (depth == 2'd0) stk_unf <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_pic10_fetch_seq.sv
// tb_pic10_fetch_seq: directed program run with a cycle-tagged scoreboard checked at the falling edge
module tb_pic10_fetch_seq;
  logic clk = 0, rst = 1, en = 0, skip_req = 0, pcl_wr = 0;
  logic [7:0] pcl_data = 0;
  logic [7:0] pm_addr, opcode_pc, retlw_k;
  logic [11:0] pm_rdata, opcode;
  logic exec_valid, retlw_wr, stk_ovf, stk_unf;
  logic [11:0] rom [256];
  int cyc = 0, checks = 0, failures = 0;

  typedef struct {
    string nm;
    int tag;
    logic [7:0] pc, opc;
    logic [11:0] op;
    logic ev, rw, ovf, unf;
  } exp_t;
  exp_t q[$];

  pic10_fetch_seq dut (
    .clk(clk), .rst(rst), .en(en), .pm_addr(pm_addr), .pm_rdata(pm_rdata),
    .skip_req(skip_req), .pcl_wr(pcl_wr), .pcl_data(pcl_data), .opcode(opcode),
    .opcode_pc(opcode_pc), .exec_valid(exec_valid), .retlw_wr(retlw_wr),
    .retlw_k(retlw_k), .stk_ovf(stk_ovf), .stk_unf(stk_unf)
  );

  assign pm_rdata = rom[pm_addr];
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function void chk(string nm, string what, logic [11:0] act, logic [11:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s %s: got %h expected %h", nm, what, act, req);
    end
  endfunction

  always @(negedge clk) begin
    if (q.size() > 0 && q[0].tag < cyc) begin
      exp_t m;
      m = q.pop_front();
      failures++;
      $display("FAIL %s missed: tag %0d at cycle %0d", m.nm, m.tag, cyc);
    end
    if (q.size() > 0 && q[0].tag == cyc) begin
      exp_t e;
      e = q.pop_front();
      chk(e.nm, "pm_addr", {4'h0, pm_addr}, {4'h0, e.pc});
      chk(e.nm, "opcode", opcode, e.op);
      chk(e.nm, "exec_valid", {11'h0, exec_valid}, {11'h0, e.ev});
      if (e.ev) chk(e.nm, "opcode_pc", {4'h0, opcode_pc}, {4'h0, e.opc});
      chk(e.nm, "retlw_wr", {11'h0, retlw_wr}, {11'h0, e.rw});
      chk(e.nm, "retlw_k", {4'h0, retlw_k}, {4'h0, e.op[7:0]});
      chk(e.nm, "stk_ovf", {11'h0, stk_ovf}, {11'h0, e.ovf});
      chk(e.nm, "stk_unf", {11'h0, stk_unf}, {11'h0, e.unf});
    end
  end

  task automatic step(string nm, logic r, logic e, logic sk, logic pw, logic [7:0] pd,
                      logic [7:0] pc, logic [11:0] op, logic [7:0] opc,
                      logic ev, logic rw, logic ovf, logic unf);
    exp_t x;
    @(posedge clk);
    #1;
    rst = r; en = e; skip_req = sk; pcl_wr = pw; pcl_data = pd;
    x.nm = nm; x.tag = cyc; x.pc = pc; x.op = op; x.opc = opc;
    x.ev = ev; x.rw = rw; x.ovf = ovf; x.unf = unf;
    q.push_back(x);
  endtask

  initial begin
    foreach (rom[i]) rom[i] = 12'h000;
    rom[8'hFF] = 12'hC25;
    rom[8'h03] = 12'h910;
    rom[8'h05] = 12'hA40;
    rom[8'h10] = 12'h855;
    rom[8'h40] = 12'hA20;
    rom[8'h21] = 12'hC77;
    rom[8'h80] = 12'hA23;
    rom[8'h23] = 12'h930;
    rom[8'h30] = 12'h938;
    rom[8'h38] = 12'h93C;
    rom[8'h3C] = 12'h801;
    rom[8'h39] = 12'h802;
    rom[8'h31] = 12'h803;
    //         name        rst en sk pw pd     pc     op       opc    ev rw ovf unf
    step("reset",          1, 0, 0, 0, 8'h00, 8'hFF, 12'h000, 8'h00, 0, 0, 0, 0);
    step("rel",            0, 1, 0, 0, 8'h00, 8'hFF, 12'h000, 8'h00, 0, 0, 0, 0);
    step("first_movlw",    0, 1, 0, 0, 8'h00, 8'h00, 12'hC25, 8'hFF, 1, 0, 0, 0);
    step("wrap_0",         0, 1, 0, 0, 8'h00, 8'h01, 12'h000, 8'h00, 1, 0, 0, 0);
    step("seq_1",          0, 1, 0, 0, 8'h00, 8'h02, 12'h000, 8'h01, 1, 0, 0, 0);
    step("seq_2",          0, 1, 0, 0, 8'h00, 8'h03, 12'h000, 8'h02, 1, 0, 0, 0);
    step("call_exec",      0, 1, 0, 0, 8'h00, 8'h04, 12'h910, 8'h03, 1, 0, 0, 0);
    step("call_bubble",    0, 1, 0, 0, 8'h00, 8'h10, 12'h000, 8'h00, 0, 0, 0, 0);
    step("retlw_55",       0, 1, 0, 0, 8'h00, 8'h11, 12'h855, 8'h10, 1, 1, 0, 0);
    step("ret_bubble",     0, 1, 0, 0, 8'h00, 8'h04, 12'h000, 8'h00, 0, 0, 0, 0);
    step("ret_to_04",      0, 1, 0, 0, 8'h00, 8'h05, 12'h000, 8'h04, 1, 0, 0, 0);
    step("goto_exec",      0, 1, 0, 0, 8'h00, 8'h06, 12'hA40, 8'h05, 1, 0, 0, 0);
    step("goto_bubble",    0, 1, 0, 0, 8'h00, 8'h40, 12'h000, 8'h00, 0, 0, 0, 0);
    step("at_40",          0, 1, 0, 0, 8'h00, 8'h41, 12'hA20, 8'h40, 1, 0, 0, 0);
    step("skip_in_bubble", 0, 1, 1, 0, 8'h00, 8'h20, 12'h000, 8'h00, 0, 0, 0, 0);
    step("skip_at_20",     0, 1, 1, 0, 8'h00, 8'h21, 12'h000, 8'h20, 1, 0, 0, 0);
    step("skip_bubble",    0, 1, 0, 0, 8'h00, 8'h22, 12'h000, 8'h00, 0, 0, 0, 0);
    step("stall_0",        0, 0, 0, 0, 8'h00, 8'h23, 12'h000, 8'h22, 1, 0, 0, 0);
    step("stall_1",        0, 0, 0, 1, 8'h80, 8'h23, 12'h000, 8'h22, 1, 0, 0, 0);
    step("stall_2",        0, 0, 1, 0, 8'h00, 8'h23, 12'h000, 8'h22, 1, 0, 0, 0);
    step("pcl_wr",         0, 1, 0, 1, 8'h80, 8'h23, 12'h000, 8'h22, 1, 0, 0, 0);
    step("pcl_bubble",     0, 1, 0, 0, 8'h00, 8'h80, 12'h000, 8'h00, 0, 0, 0, 0);
    step("at_80",          0, 1, 0, 0, 8'h00, 8'h81, 12'hA23, 8'h80, 1, 0, 0, 0);
    step("goto23_bub",     0, 1, 0, 0, 8'h00, 8'h23, 12'h000, 8'h00, 0, 0, 0, 0);
    step("call1",          0, 1, 0, 0, 8'h00, 8'h24, 12'h930, 8'h23, 1, 0, 0, 0);
    step("call1_bub",      0, 1, 0, 0, 8'h00, 8'h30, 12'h000, 8'h00, 0, 0, 0, 0);
    step("call2",          0, 1, 0, 0, 8'h00, 8'h31, 12'h938, 8'h30, 1, 0, 0, 0);
    step("call2_bub",      0, 1, 0, 0, 8'h00, 8'h38, 12'h000, 8'h00, 0, 0, 0, 0);
    step("call3",          0, 1, 0, 0, 8'h00, 8'h39, 12'h93C, 8'h38, 1, 0, 0, 0);
    step("ovf_set",        0, 1, 0, 0, 8'h00, 8'h3C, 12'h000, 8'h00, 0, 0, 1, 0);
    step("ret1",           0, 1, 0, 0, 8'h00, 8'h3D, 12'h801, 8'h3C, 1, 1, 1, 0);
    step("ret1_bub",       0, 1, 0, 0, 8'h00, 8'h39, 12'h000, 8'h00, 0, 0, 1, 0);
    step("ret2",           0, 1, 0, 0, 8'h00, 8'h3A, 12'h802, 8'h39, 1, 1, 1, 0);
    step("ret2_bub",       0, 1, 0, 0, 8'h00, 8'h31, 12'h000, 8'h00, 0, 0, 1, 0);
    step("ret3",           0, 1, 0, 0, 8'h00, 8'h32, 12'h803, 8'h31, 1, 1, 1, 0);
    step("unf_set",        0, 1, 0, 0, 8'h00, 8'h31, 12'h000, 8'h00, 0, 0, 1, 1);
    step("stall_retlw",    0, 0, 0, 0, 8'h00, 8'h32, 12'h803, 8'h31, 1, 0, 1, 1);
    step("rst_in_stall",   1, 0, 0, 0, 8'h00, 8'hFF, 12'h000, 8'h00, 0, 0, 0, 0);
    step("post_rst_hold",  0, 0, 0, 0, 8'h00, 8'hFF, 12'h000, 8'h00, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard: %0d expectations left unchecked, required 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
